// File: rtl/opb_fwd_pkg.sv
// Shared constants for the operand-B forwarding stage: forward-source tags,
// source slot indices and the select-width helper.
package opb_fwd_pkg;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_EX   = 2'd1;
  localparam logic [1:0] FWD_MEM  = 2'd2;

  localparam int SRC_RS2 = 0;
  localparam int SRC_PC  = 1;
  localparam int SRC_IMI = 2;
  localparam int SRC_IMS = 3;

  function automatic int sel_width(input int nsrc);
    return (nsrc > 1) ? $clog2(nsrc) : 1;
  endfunction

endpackage

// File: rtl/opb_fwd_stage_fwd_select.sv
// Combinational operand-B source select with EX/MEM result forwarding and
// load-use hazard detection. Only the rs2 slot is eligible for forwarding.
module opb_fwd_stage_fwd_select
  import opb_fwd_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSRC = 4,
  parameter int REGW = 5,
  parameter int SELW = 2
) (
  input  logic [SELW-1:0]      sel_i,
  input  logic [NSRC*XLEN-1:0] src_i,
  input  logic [REGW-1:0]      rs2_addr_i,
  input  logic                 ex_wen_i,
  input  logic [REGW-1:0]      ex_waddr_i,
  input  logic [XLEN-1:0]      ex_wdata_i,
  input  logic                 ex_is_load_i,
  input  logic                 mem_wen_i,
  input  logic [REGW-1:0]      mem_waddr_i,
  input  logic [XLEN-1:0]      mem_wdata_i,
  output logic [XLEN-1:0]      opb_o,
  output logic [1:0]           fwd_o,
  output logic                 hazard_o
);

  logic [XLEN-1:0] src_arr [NSRC];

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_unpack
      assign src_arr[gi] = src_i[gi*XLEN +: XLEN];
    end
  endgenerate

  logic rs2_nz;
  logic ex_hit;
  logic mem_hit;
  logic sel_rs2;

  assign rs2_nz  = (rs2_addr_i != '0);
  assign ex_hit  = ex_wen_i  && (ex_waddr_i  == rs2_addr_i) && rs2_nz;
  assign mem_hit = mem_wen_i && (mem_waddr_i == rs2_addr_i) && rs2_nz;
  assign sel_rs2 = (sel_i == SELW'(SRC_RS2));

  // EX is the younger writer, so a pending EX load blocks even when MEM matches.
  assign hazard_o = sel_rs2 && ex_hit && ex_is_load_i;

  always_comb begin
    opb_o = '0;
    fwd_o = FWD_NONE;
    if (sel_rs2) begin
      if (ex_hit && !ex_is_load_i) begin
        opb_o = ex_wdata_i;
        fwd_o = FWD_EX;
      end else if (mem_hit) begin
        opb_o = mem_wdata_i;
        fwd_o = FWD_MEM;
      end else begin
        opb_o = src_arr[SRC_RS2];
      end
    end else begin
      // Selects at or beyond NSRC match no slot and leave the zero default.
      for (int k = 1; k < NSRC; k++) begin
        if (sel_i == SELW'(k)) begin
          opb_o = src_arr[k];
        end
      end
    end
  end

endmodule

// File: rtl/opb_fwd_stage.sv
// Registered ALU operand-B stage: forwarded source select behind a
// valid/ready handshake, with flush and a saturating load-use stall counter.
module opb_fwd_stage
  import opb_fwd_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSRC = 4,
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [opb_fwd_pkg::sel_width(NSRC)-1:0] in_sel,
  input  logic [NSRC*XLEN-1:0]                 in_src,
  input  logic [REGW-1:0]                      in_rs2_addr,
  input  logic                                 ex_wen,
  input  logic [REGW-1:0]                      ex_waddr,
  input  logic [XLEN-1:0]                      ex_wdata,
  input  logic                                 ex_is_load,
  input  logic                                 mem_wen,
  input  logic [REGW-1:0]                      mem_waddr,
  input  logic [XLEN-1:0]                      mem_wdata,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [XLEN-1:0]                      out_opb,
  output logic [1:0]                           out_fwd,
  output logic [CNTW-1:0]                      stall_cnt
);

  localparam int SELW = sel_width(NSRC);

  logic [XLEN-1:0] sel_opb;
  logic [1:0]      sel_fwd;
  logic            hazard;

  opb_fwd_stage_fwd_select #(
    .XLEN (XLEN),
    .NSRC (NSRC),
    .REGW (REGW),
    .SELW (SELW)
  ) u_fwd_select (
    .sel_i        (in_sel),
    .src_i        (in_src),
    .rs2_addr_i   (in_rs2_addr),
    .ex_wen_i     (ex_wen),
    .ex_waddr_i   (ex_waddr),
    .ex_wdata_i   (ex_wdata),
    .ex_is_load_i (ex_is_load),
    .mem_wen_i    (mem_wen),
    .mem_waddr_i  (mem_waddr),
    .mem_wdata_i  (mem_wdata),
    .opb_o        (sel_opb),
    .fwd_o        (sel_fwd),
    .hazard_o     (hazard)
  );

  logic            valid_q, valid_d;
  logic [XLEN-1:0] opb_q,   opb_d;
  logic [1:0]      fwd_q,   fwd_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic            capture;

  assign in_ready = !hazard && (!valid_q || out_ready) && !flush;
  assign capture  = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    opb_d   = opb_q;
    fwd_d   = fwd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      opb_d   = sel_opb;
      fwd_d   = sel_fwd;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    // Counts stalled requests regardless of flush; sticks at all-ones.
    if (in_valid && hazard && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      opb_q   <= '0;
      fwd_q   <= FWD_NONE;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      opb_q   <= opb_d;
      fwd_q   <= fwd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_opb   = opb_q;
  assign out_fwd   = fwd_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_opb_fwd_stage.sv
// Self-checking bench for opb_fwd_stage: directed scenarios plus randomized
// traffic against a behavioural reference of the forwarding/handshake rules.
module tb_opb_fwd_stage;
  import opb_fwd_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_sel = 2'd0;
  logic [1:0]  in_sel_b = 2'd1;
  logic [31:0] src [4];
  logic [127:0] in_src;
  logic [95:0]  in_src_b;
  logic [4:0]  in_rs2_addr = 5'd0;
  logic        ex_wen = 1'b0;
  logic [4:0]  ex_waddr = 5'd0;
  logic [31:0] ex_wdata = 32'd0;
  logic        ex_is_load = 1'b0;
  logic        mem_wen = 1'b0;
  logic [4:0]  mem_waddr = 5'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_opb;
  logic [1:0]  out_fwd;
  logic [15:0] stall_cnt;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_opb;
  logic [1:0]  b_out_fwd;
  logic [3:0]  b_stall_cnt;

  assign in_src   = {src[3], src[2], src[1], src[0]};
  assign in_src_b = {src[2], src[1], src[0]};

  always #5 clk = ~clk;

  opb_fwd_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_src(in_src), .in_rs2_addr(in_rs2_addr),
    .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_opb(out_opb), .out_fwd(out_fwd),
    .stall_cnt(stall_cnt)
  );

  opb_fwd_stage #(.NSRC(3), .CNTW(4)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_sel(in_sel_b), .in_src(in_src_b), .in_rs2_addr(in_rs2_addr),
    .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_opb(b_out_opb), .out_fwd(b_out_fwd),
    .stall_cnt(b_stall_cnt)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference state for the main instance.
  logic        m_valid = 1'b0;
  logic [31:0] m_opb = 32'd0;
  logic [1:0]  m_fwd = 2'd0;
  int          m_cnt = 0;
  logic        exp_ready;

  // Operand B as the architecture defines it: the youngest writer of rs2 wins,
  // x0 is never forwarded, and an in-flight load in EX cannot supply data yet.
  function automatic void ref_pick(output logic [31:0] v, output logic [1:0] t, output logic h);
    v = 32'd0;
    t = FWD_NONE;
    h = 1'b0;
    if (in_sel != 2'd0) begin
      v = src[in_sel];
      return;
    end
    if (in_rs2_addr != 5'd0 && ex_wen && ex_waddr == in_rs2_addr) begin
      if (ex_is_load) h = 1'b1;
      else begin
        v = ex_wdata;
        t = FWD_EX;
      end
      return;
    end
    if (in_rs2_addr != 5'd0 && mem_wen && mem_waddr == in_rs2_addr) begin
      v = mem_wdata;
      t = FWD_MEM;
      return;
    end
    v = src[0];
  endfunction

  function automatic logic model_ready();
    logic [31:0] v;
    logic [1:0]  t;
    logic        h;
    ref_pick(v, t, h);
    return !h && (!m_valid || out_ready) && !flush;
  endfunction

  // Advance one clock with the currently driven inputs and update the model.
  task automatic step();
    logic [31:0] v;
    logic [1:0]  t;
    logic        h;
    #1;
    ref_pick(v, t, h);
    exp_ready = !h && (!m_valid || out_ready) && !flush;
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (in_valid && exp_ready) begin
      m_valid = 1'b1;
      m_opb   = v;
      m_fwd   = t;
    end else if (out_ready) m_valid = 1'b0;
    if (in_valid && h && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  task automatic clear_writers();
    ex_wen = 1'b0; ex_is_load = 1'b0; mem_wen = 1'b0;
    ex_waddr = 5'd0; mem_waddr = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    m_valid = 0; m_opb = 0; m_fwd = 0; m_cnt = 0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_opb !== 32'd0) $display("FAIL reset_opb got %h want 0", out_opb); else n_pass++;
    n_total++; if (out_fwd !== 2'd0) $display("FAIL reset_fwd got %0d want 0", out_fwd); else n_pass++;
    n_total++; if (stall_cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", stall_cnt); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_plain_select();
    src[0] = 32'h0000_0AA0; src[1] = 32'h0000_1000; src[2] = 32'h0000_0123; src[3] = 32'h0000_0456;
    in_valid = 1'b1; out_ready = 1'b1; in_sel = 2'(SRC_IMI);
    step();
    n_total++; if (out_valid !== 1'b1) $display("FAIL plain_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_opb !== 32'h123) $display("FAIL plain_opb got %h want 00000123", out_opb); else n_pass++;
    n_total++; if (out_fwd !== FWD_NONE) $display("FAIL plain_fwd got %0d want 0", out_fwd); else n_pass++;
    in_sel = 2'(SRC_PC);
    step();
    n_total++; if (out_opb !== 32'h1000) $display("FAIL plain_pc got %h want 00001000", out_opb); else n_pass++;
    $display("plain select: opb=%h fwd=%0d", out_opb, out_fwd);
  endtask

  task automatic test_out_of_range();
    in_sel_b = 2'd3;
    step();
    n_total++; if (b_out_valid !== 1'b1) $display("FAIL oor_valid got %b want 1", b_out_valid); else n_pass++;
    n_total++; if (b_out_opb !== 32'd0) $display("FAIL oor_opb got %h want 0", b_out_opb); else n_pass++;
    n_total++; if (b_out_fwd !== FWD_NONE) $display("FAIL oor_fwd got %0d want 0", b_out_fwd); else n_pass++;
    in_sel_b = 2'd1;
    $display("out of range select: opb=%h", b_out_opb);
  endtask

  task automatic test_forward();
    in_sel = 2'(SRC_RS2); in_rs2_addr = 5'd5;
    ex_wen = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hAAAA_0001;
    mem_wen = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'hBBBB_0002;
    step();
    n_total++; if (out_opb !== 32'hAAAA_0001) $display("FAIL fwd_ex_opb got %h want aaaa0001", out_opb); else n_pass++;
    n_total++; if (out_fwd !== FWD_EX) $display("FAIL fwd_ex_tag got %0d want 1", out_fwd); else n_pass++;
    ex_wen = 1'b0;
    step();
    n_total++; if (out_opb !== 32'hBBBB_0002) $display("FAIL fwd_mem_opb got %h want bbbb0002", out_opb); else n_pass++;
    n_total++; if (out_fwd !== FWD_MEM) $display("FAIL fwd_mem_tag got %0d want 2", out_fwd); else n_pass++;
    in_rs2_addr = 5'd0; ex_wen = 1'b1; ex_waddr = 5'd0; mem_waddr = 5'd0;
    step();
    n_total++; if (out_opb !== 32'h0000_0AA0) $display("FAIL fwd_x0_opb got %h want 00000aa0", out_opb); else n_pass++;
    n_total++; if (out_fwd !== FWD_NONE) $display("FAIL fwd_x0_tag got %0d want 0", out_fwd); else n_pass++;
    clear_writers();
    $display("forward priority: last opb=%h fwd=%0d", out_opb, out_fwd);
  endtask

  task automatic test_load_use();
    in_sel = 2'(SRC_RS2); in_rs2_addr = 5'd7;
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'hDEAD_0007;
    mem_wen = 1'b1; mem_waddr = 5'd7; mem_wdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (in_ready !== 1'b0) $display("FAIL loaduse_ready cyc %0d got %b want 0", i, in_ready); else n_pass++;
      step();
    end
    n_total++; if (stall_cnt !== 16'd3) $display("FAIL loaduse_cnt got %0d want 3", stall_cnt); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL loaduse_drain got %b want 0", out_valid); else n_pass++;
    ex_is_load = 1'b0;
    step();
    n_total++; if (out_opb !== 32'hDEAD_0007) $display("FAIL loaduse_opb got %h want dead0007", out_opb); else n_pass++;
    n_total++; if (out_fwd !== FWD_EX) $display("FAIL loaduse_tag got %0d want 1", out_fwd); else n_pass++;
    clear_writers();
    $display("load-use: stall_cnt=%0d opb=%h", stall_cnt, out_opb);
  endtask

  task automatic test_backpressure();
    in_sel = 2'(SRC_IMS); src[3] = 32'h11; out_ready = 1'b1; in_valid = 1'b1;
    step();
    n_total++; if (out_opb !== 32'h11) $display("FAIL bp_first got %h want 11", out_opb); else n_pass++;
    out_ready = 1'b0; src[3] = 32'h99;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ready got %b want 0", in_ready); else n_pass++;
    step();
    n_total++; if (out_opb !== 32'h11) $display("FAIL bp_hold got %h want 11", out_opb); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", out_valid); else n_pass++;
    src[3] = 32'h22; out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release got %b want 1", in_ready); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b1) $display("FAIL bp_b2b_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_opb !== 32'h22) $display("FAIL bp_b2b_opb got %h want 22", out_opb); else n_pass++;
    $display("backpressure: opb=%h valid=%b", out_opb, out_valid);
  endtask

  task automatic test_flush();
    src[3] = 32'h33; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL flush_ready got %b want 0", in_ready); else n_pass++;
    step();
    flush = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_opb !== 32'h22) $display("FAIL flush_nocap got %h want 22", out_opb); else n_pass++;
    $display("flush: valid=%b opb=%h", out_valid, out_opb);
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = n_total - n_pass;
    for (int i = 0; i < 300; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      in_sel      = 2'($urandom_range(0, 3));
      in_rs2_addr = 5'($urandom_range(0, 3));
      ex_wen      = $urandom_range(0, 1) == 1;
      ex_is_load  = ($urandom_range(0, 3) == 0);
      ex_waddr    = 5'($urandom_range(0, 3));
      ex_wdata    = $urandom;
      mem_wen     = $urandom_range(0, 1) == 1;
      mem_waddr   = 5'($urandom_range(0, 3));
      mem_wdata   = $urandom;
      for (int k = 0; k < 4; k++) src[k] = $urandom;
      #1;
      n_total++; if (in_ready !== model_ready()) $display("FAIL rnd_ready cyc %0d got %b want %b", i, in_ready, model_ready()); else n_pass++;
      step();
      n_total++; if (out_valid !== m_valid) $display("FAIL rnd_valid cyc %0d got %b want %b", i, out_valid, m_valid); else n_pass++;
      n_total++; if (out_opb !== m_opb) $display("FAIL rnd_opb cyc %0d got %h want %h", i, out_opb, m_opb); else n_pass++;
      n_total++; if (out_fwd !== m_fwd) $display("FAIL rnd_fwd cyc %0d got %0d want %0d", i, out_fwd, m_fwd); else n_pass++;
      n_total++; if (stall_cnt !== 16'(m_cnt)) $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, stall_cnt, m_cnt); else n_pass++;
    end
    flush = 1'b0;
    clear_writers();
    $display("random: 300 cycles, %0d new failures, stall_cnt=%0d", (n_total - n_pass) - errs_before, stall_cnt);
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_sel = 2'(SRC_PC); src[1] = 32'hCAFE_F00D;
    step();
    n_total++; if (out_opb !== 32'hCAFE_F00D) $display("FAIL areset_pre got %h want cafef00d", out_opb); else n_pass++;
    #3 reset = 1'b1;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL areset_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_opb !== 32'd0) $display("FAIL areset_opb got %h want 0", out_opb); else n_pass++;
    n_total++; if (out_fwd !== 2'd0) $display("FAIL areset_fwd got %0d want 0", out_fwd); else n_pass++;
    n_total++; if (stall_cnt !== 16'd0) $display("FAIL areset_cnt got %0d want 0", stall_cnt); else n_pass++;
    n_total++; if (b_out_valid !== 1'b0) $display("FAIL areset_b_valid got %b want 0", b_out_valid); else n_pass++;
    @(posedge clk);
    #2 reset = 1'b0;
    m_valid = 0; m_opb = 0; m_fwd = 0; m_cnt = 0;
    $display("async reset: outputs cleared between edges");
  endtask

  task automatic test_saturation();
    in_valid = 1'b1; out_ready = 1'b1;
    in_sel = 2'(SRC_RS2); in_sel_b = 2'd0; in_rs2_addr = 5'd9;
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd9;
    repeat (20) step();
    n_total++; if (b_stall_cnt !== 4'd15) $display("FAIL sat_cnt got %0d want 15", b_stall_cnt); else n_pass++;
    n_total++; if (b_in_ready !== 1'b0) $display("FAIL sat_ready got %b want 0", b_in_ready); else n_pass++;
    n_total++; if (stall_cnt !== 16'(m_cnt)) $display("FAIL sat_main_cnt got %0d want %0d", stall_cnt, m_cnt); else n_pass++;
    clear_writers();
    in_valid = 1'b0; in_sel_b = 2'd1;
    $display("saturation: narrow stall_cnt=%0d wide stall_cnt=%0d", b_stall_cnt, stall_cnt);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) src[k] = 32'd0;
    test_reset();
    test_plain_select();
    test_out_of_range();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
